nios2_onchip_ram_arbiter: RTL and testbench
===========================================

Name: nios2_onchip_ram_arbiter

Overview:
- Shares one port of a 128x16 byte-enabled on-chip RAM (Avalon slave, 7-bit word address, 1-cycle read latency) between two Avalon-MM requesters m0 and m1.
- Round-robin arbitration with a bounded consecutive-grant limit.
- Pipelined issue: at most one command per cycle; read data routed back by a tag pipeline.
- Sits between the Nios II data master / DMA-side masters and the RAM's s1 or s2 port.

Parameters:
- ADDR_W, 7, RAM word-address width
- DATA_W, 16, data width
- BE_W, 2, byteenable width (DATA_W/8)
- MAX_GRANT, 4, max consecutive grants to one master while the other is requesting (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  requester 0 word address
- m0_byteenable  in  BE_W  requester 0 byte lanes
- m0_read  in  1  requester 0 read request
- m0_write  in  1  requester 0 write request
- m0_writedata  in  DATA_W  requester 0 write data
- m0_waitrequest  out  1  command not accepted this cycle
- m0_readdata  out  DATA_W  read data
- m0_readdatavalid  out  1  m0_readdata valid
- m1_*  same six inputs and four outputs as m0_*, for requester 1
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  BE_W  to RAM byteenable
- ram_chipselect  out  1  to RAM chipselect
- ram_write  out  1  to RAM write
- ram_writedata  out  DATA_W  to RAM writedata
- ram_clken  out  1  RAM clock enable; tied 1 except during reset
- ram_readdata  in  DATA_W  RAM readdata, valid one cycle after read issue

Behaviour:
- Request: reqN = mN_read | mN_write. Read and write both asserted is illegal; treat as write, and the assertion checker flags it.
- Grant is combinational each cycle from reqN, last_grant (reg, reset 1 so m0 wins first) and run_cnt (reg, reset 0).
- Grant rules:
  - only one requester -> grant it;
  - both requesting -> grant the master != last_grant, unless run_cnt < MAX_GRANT and that master is also requesting, in which case stay with last_grant.
- Effect: bursts up to MAX_GRANT back-to-back, then a forced switch.
- Accepted master: mN_waitrequest=0. Ungranted requester: mN_waitrequest=1. Idle master: waitrequest=0 (don't care per Avalon, fixed at 0).
- On grant, drive the RAM port: ram_chipselect=1, ram_write=mN_write, address/byteenable/writedata = master's. No grant -> ram_chipselect=0, ram_write=0, other RAM outputs hold the last value.
- Registers updated on every grant:
  - last_grant <= granted master.
  - run_cnt <= (granted == last_grant) ? sat(run_cnt+1, MAX_GRANT) : 1.
  - Idle cycle: run_cnt <= 0, last_grant unchanged.
- Read return:
  - rd_pend (1b) and rd_tag (1b) are registered at issue.
  - Next cycle: mT_readdatavalid = rd_pend & (rd_tag==T); mT_readdata = ram_readdata.
  - Other master's readdatavalid = 0; its readdata = ram_readdata (don't care).
- Latency: 1 cycle issue-to-readdatavalid. Throughput: one command per cycle, no bubbles between masters.
- Write: completes on the accept cycle; no response.
- Reset (synchronous), while reset=1:
  - all waitrequest=1, readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0;
  - rd_pend<=0, run_cnt<=0, last_grant<=1.
- Reset mid-read: the pending readdatavalid is dropped and never emitted after reset deasserts.
- Reset deassert: first grant is possible in the same cycle reset falls.
- Requester drops request while waiting: allowed; no state change.
- MAX_GRANT=1: strict alternation under contention.

Decomposition:
- Package nios2_ram_arb_pkg: ADDR_W/DATA_W/BE_W defaults; grant index type (1-bit master id); constants M0=0, M1=1.
- One natural sub-module, nios2_rr_grant: 2-way round-robin grant logic with run_cnt/last_grant and MAX_GRANT. The top level keeps muxing and the read-tag pipeline.

Test Plan:
- m0 writes 0xBEEF to addr 0x05 (be=11), then m1 reads 0x05 -> m1_readdatavalid exactly 1 cycle after accept, m1_readdata=0xBEEF, m0_readdatavalid=0.
- m0 writes 0x1234 to addr 0x7F with be=01 over an old 0xFFFF, then reads -> 0xFF34 (byte lanes respected, top address works).
- Both masters issue continuous reads, MAX_GRANT=4 -> grant pattern m0x4, m1x4, m0x4...; each readdatavalid to the correct tag; zero idle cycles on ram_chipselect.
- Both request, MAX_GRANT=1 -> strict alternation m0,m1,m0,m1; the waiting master's waitrequest=1 every other cycle.
- m0 read accepted, reset asserted the next cycle -> m0_readdatavalid stays 0, all waitrequest=1 and ram_chipselect=0 during reset, first grant after reset goes to m0.
- Idle gap of 1 cycle within an m1 run -> run_cnt clears; m1 may again take MAX_GRANT consecutive grants before switching.

Source files
------------

// File: rtl/nios2_ram_arb_pkg.sv
// Shared definitions for the two-master on-chip RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF / BE_W_DEF : default RAM port geometry (128 x 16, 2 byte lanes)
//   master_id_t                        : 1-bit requester id (M0 / M1)
//   other_master()                     : the opposite requester id
package nios2_ram_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 7;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned BE_W_DEF   = 2;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_id_t;

   function automatic master_id_t other_master(input master_id_t m);
      return (m == M0) ? M1 : M0;
   endfunction

endpackage

// File: rtl/nios2_rr_grant.sv
// Two-way round-robin grant with a bounded consecutive-grant run.
//   clk, reset     : system clock, synchronous active-high reset
//   req0, req1     : requester 0 / 1 wants the RAM port this cycle
//   gnt_valid      : a requester is granted this cycle (never during reset)
//   gnt_id         : which requester is granted (valid with gnt_valid)
module nios2_rr_grant
   import nios2_ram_arb_pkg::*;
#(
   parameter int unsigned MAX_GRANT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   output logic       gnt_valid,
   output master_id_t gnt_id
);

   localparam logic [3:0] MAX_G = 4'(MAX_GRANT);

   master_id_t last_grant;
   logic [3:0] run_cnt;
   logic       stay;

   // Under contention the previous winner keeps the port only while a run is
   // actually in progress (run_cnt != 0) and still short of MAX_GRANT. A
   // cleared run (after reset or an idle cycle) hands contention to the other
   // master, which is why m0 wins first out of reset (last_grant resets to M1).
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = last_grant;
      stay      = 1'b0;
      if (!reset) begin
         case ({req1, req0})
            2'b01: begin
               gnt_valid = 1'b1;
               gnt_id    = M0;
            end
            2'b10: begin
               gnt_valid = 1'b1;
               gnt_id    = M1;
            end
            2'b11: begin
               gnt_valid = 1'b1;
               stay      = (run_cnt != '0) && (run_cnt < MAX_G);
               gnt_id    = stay ? last_grant : other_master(last_grant);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= M1;
         run_cnt    <= '0;
      end else if (gnt_valid) begin
         last_grant <= gnt_id;
         if (gnt_id == last_grant)
            run_cnt <= (run_cnt >= MAX_G) ? MAX_G : 4'(run_cnt + 4'd1);
         else
            run_cnt <= 4'd1;
      end else begin
         run_cnt <= '0;
      end
   end

endmodule

// File: rtl/nios2_onchip_ram_arbiter.sv
// Shares one Avalon port of a 128x16 byte-enabled on-chip RAM between two
// Avalon-MM requesters, one command per cycle, 1-cycle read return.
//   clk, reset                 : system clock, synchronous active-high reset
//   mN_address/byteenable/
//   mN_read/write/writedata    : requester N command (write wins if both read and write)
//   mN_waitrequest             : 1 = requester N command not accepted this cycle
//   mN_readdata/readdatavalid  : read return, one cycle after acceptance
//   ram_address/byteenable/
//   ram_chipselect/write/
//   ram_writedata/clken        : RAM slave command side
//   ram_readdata               : RAM read data, valid one cycle after a read issue
module nios2_onchip_ram_arbiter
   import nios2_ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned BE_W      = BE_W_DEF,
   parameter int unsigned MAX_GRANT = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata
);

   logic              req0, req1;
   logic              gnt_valid;
   master_id_t        gnt_id;

   logic [ADDR_W-1:0] sel_addr;
   logic [BE_W-1:0]   sel_be;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_write;

   logic [ADDR_W-1:0] hold_addr;
   logic [BE_W-1:0]   hold_be;
   logic [DATA_W-1:0] hold_wdata;

   logic              rd_pend;
   master_id_t        rd_tag;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   nios2_rr_grant #(
      .MAX_GRANT (MAX_GRANT)
   ) u_grant (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      sel_addr  = m0_address;
      sel_be    = m0_byteenable;
      sel_wdata = m0_writedata;
      sel_write = m0_write;
      if (gnt_id == M1) begin
         sel_addr  = m1_address;
         sel_be    = m1_byteenable;
         sel_wdata = m1_writedata;
         sel_write = m1_write;
      end
   end

   // RAM command side: idle cycles replay the last command fields with
   // chipselect low so the address/data buses do not toggle needlessly.
   assign ram_chipselect = gnt_valid;
   assign ram_write      = gnt_valid & sel_write;
   assign ram_address    = gnt_valid ? sel_addr  : hold_addr;
   assign ram_byteenable = gnt_valid ? sel_be    : hold_be;
   assign ram_writedata  = gnt_valid ? sel_wdata : hold_wdata;
   assign ram_clken      = ~reset;

   assign m0_waitrequest = reset | (req0 & ~(gnt_valid & (gnt_id == M0)));
   assign m1_waitrequest = reset | (req1 & ~(gnt_valid & (gnt_id == M1)));

   // Gating with reset drops a read that was issued the cycle before reset.
   assign m0_readdatavalid = rd_pend & ~reset & (rd_tag == M0);
   assign m1_readdatavalid = rd_pend & ~reset & (rd_tag == M1);
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend    <= 1'b0;
         rd_tag     <= M0;
         hold_addr  <= '0;
         hold_be    <= '0;
         hold_wdata <= '0;
      end else begin
         rd_pend <= gnt_valid & ~sel_write;
         if (gnt_valid) begin
            rd_tag     <= gnt_id;
            hold_addr  <= sel_addr;
            hold_be    <= sel_be;
            hold_wdata <= sel_wdata;
         end
      end
   end

   a_m0_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
   a_m1_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_nios2_onchip_ram_arbiter.sv
// Bench for nios2_onchip_ram_arbiter: two instances (MAX_GRANT 4 and 1) share
// the same stimulus, each with its own RAM and its own reference model.
module tb_nios2_onchip_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        preload;
   logic        rec;

   logic [6:0]  m0_address, m1_address;
   logic [1:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [15:0] m0_writedata, m1_writedata;

   logic        w0 [2];
   logic        w1 [2];
   logic        v0 [2];
   logic        v1 [2];
   logic [15:0] d0 [2];
   logic [15:0] d1 [2];
   logic [6:0]  ra [2];
   logic [1:0]  rbe [2];
   logic        cs [2];
   logic        wr [2];
   logic [15:0] rwd [2];
   logic        ck [2];
   logic [15:0] rrd [2];

   logic [15:0] mem [2][128];

   int n_chk  = 0;
   int n_pass = 0;

   int maxg [2] = '{4, 1};
   int glog0 [$];
   int glog1 [$];

   always #5 clk = ~clk;

   nios2_onchip_ram_arbiter #(.MAX_GRANT(4)) dut4 (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(w0[0]),
      .m0_readdata(d0[0]), .m0_readdatavalid(v0[0]),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(w1[0]),
      .m1_readdata(d1[0]), .m1_readdatavalid(v1[0]),
      .ram_address(ra[0]), .ram_byteenable(rbe[0]), .ram_chipselect(cs[0]),
      .ram_write(wr[0]), .ram_writedata(rwd[0]), .ram_clken(ck[0]),
      .ram_readdata(rrd[0])
   );

   nios2_onchip_ram_arbiter #(.MAX_GRANT(1)) dut1 (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(w0[1]),
      .m0_readdata(d0[1]), .m0_readdatavalid(v0[1]),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(w1[1]),
      .m1_readdata(d1[1]), .m1_readdatavalid(v1[1]),
      .ram_address(ra[1]), .ram_byteenable(rbe[1]), .ram_chipselect(cs[1]),
      .ram_write(wr[1]), .ram_writedata(rwd[1]), .ram_clken(ck[1]),
      .ram_readdata(rrd[1])
   );

   // Behavioural RAMs (1-cycle read latency, byte lanes), one per instance.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (preload) begin
            for (int i = 0; i < 128; i++) mem[k][i] <= 16'(32'h1000 + i * 3);
         end else if (ck[k] && cs[k]) begin
            if (wr[k]) begin
               if (rbe[k][0]) mem[k][ra[k]][7:0]  <= rwd[k][7:0];
               if (rbe[k][1]) mem[k][ra[k]][15:8] <= rwd[k][15:8];
            end else begin
               rrd[k] <= mem[k][ra[k]];
            end
         end
      end
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
   endtask

   // Reference model: memory image, arbitration by ownership runs, and one
   // outstanding read per instance.
   logic [15:0] mm [2][128];
   int          mlast [2];
   int          mrun [2];
   bit          mpend [2];
   int          mtag [2];
   logic [15:0] mdat [2];

   always @(negedge clk) begin
      int g;
      bit r0, r1, w;
      logic [6:0]  a;
      logic [1:0]  be;
      logic [15:0] wd;
      if (preload)
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 128; i++) mm[k][i] = 16'(32'h1000 + i * 3);
      r0 = m0_read || m0_write;
      r1 = m1_read || m1_write;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            chk("rst_wait0", k, w0[k], 1);
            chk("rst_wait1", k, w1[k], 1);
            chk("rst_rdv0", k, v0[k], 0);
            chk("rst_rdv1", k, v1[k], 0);
            chk("rst_cs", k, cs[k], 0);
            chk("rst_write", k, wr[k], 0);
            chk("rst_clken", k, ck[k], 0);
            mlast[k] = 1;
            mrun[k]  = 0;
            mpend[k] = 0;
         end else begin
            chk("clken", k, ck[k], 1);
            chk("rdv0", k, v0[k], mpend[k] && mtag[k] == 0);
            chk("rdv1", k, v1[k], mpend[k] && mtag[k] == 1);
            if (mpend[k]) chk("rdata", k, (mtag[k] == 0) ? d0[k] : d1[k], mdat[k]);
            if (r0 && r1) begin
               // Owner keeps the port while its unbroken run is under the limit.
               if (mrun[k] > 0 && mrun[k] < maxg[k]) g = mlast[k];
               else g = 1 - mlast[k];
            end else if (r0) g = 0;
            else if (r1) g = 1;
            else g = -1;
            chk("wait0", k, w0[k], r0 && g != 0);
            chk("wait1", k, w1[k], r1 && g != 1);
            chk("chipsel", k, cs[k], g >= 0);
            if (g >= 0) begin
               w  = (g == 0) ? m0_write : m1_write;
               a  = (g == 0) ? m0_address : m1_address;
               be = (g == 0) ? m0_byteenable : m1_byteenable;
               wd = (g == 0) ? m0_writedata : m1_writedata;
               chk("ram_write", k, wr[k], w);
               chk("ram_addr", k, ra[k], a);
               chk("ram_be", k, rbe[k], be);
               if (w) begin
                  chk("ram_wdata", k, rwd[k], wd);
                  if (be[0]) mm[k][a][7:0]  = wd[7:0];
                  if (be[1]) mm[k][a][15:8] = wd[15:8];
               end
               mpend[k] = !w;
               mtag[k]  = g;
               mdat[k]  = mm[k][a];
               if (g == mlast[k]) mrun[k] = (mrun[k] + 1 > maxg[k]) ? maxg[k] : mrun[k] + 1;
               else mrun[k] = 1;
               mlast[k] = g;
            end else begin
               chk("ram_write_idle", k, wr[k], 0);
               mrun[k]  = 0;
               mpend[k] = 0;
            end
            if (rec) begin
               if (k == 0) glog0.push_back(g);
               else glog1.push_back(g);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic set0(input bit rd, input bit wrt, input logic [6:0] a, input logic [1:0] be, input logic [15:0] wd);
      m0_read = rd; m0_write = wrt; m0_address = a; m0_byteenable = be; m0_writedata = wd;
   endtask

   task automatic set1(input bit rd, input bit wrt, input logic [6:0] a, input logic [1:0] be, input logic [15:0] wd);
      m1_read = rd; m1_write = wrt; m1_address = a; m1_byteenable = be; m1_writedata = wd;
   endtask

   initial begin
      int exp4 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
      int exp1 [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
      int gap4 [6]  = '{1, 1, 1, 0, 0, 0};
      int gap1 [6]  = '{0, 1, 0, 1, 0, 1};

      reset = 1'b1; preload = 1'b1; rec = 1'b0;
      set0(0, 0, '0, '0, '0);
      set1(0, 0, '0, '0, '0);
      tick(); tick();
      preload = 1'b0;
      tick();

      // Contention straight out of reset: both read continuously.
      reset = 1'b0; rec = 1'b1;
      set0(1, 0, 7'h05, 2'b11, '0);
      set1(1, 0, 7'h7F, 2'b11, '0);
      for (int i = 0; i < 12; i++) begin
         tick();
         if (i == 0) begin
            sample();
            for (int k = 0; k < 2; k++) begin
               chk("first_rdv0", k, v0[k], 1);
               chk("first_rdata", k, d0[k], 16'h100F);
            end
         end
      end
      rec = 1'b0;
      set0(0, 0, '0, '0, '0);
      set1(0, 0, '0, '0, '0);
      tick();
      chk("glog4_len", 0, glog0.size(), 12);
      chk("glog1_len", 1, glog1.size(), 12);
      for (int i = 0; i < 12 && i < glog0.size(); i++) chk("pattern_max4", 0, glog0[i], exp4[i]);
      for (int i = 0; i < 12 && i < glog1.size(); i++) chk("pattern_max1", 1, glog1[i], exp1[i]);

      // m0 writes 0xBEEF to 0x05, m1 reads it back.
      set0(0, 1, 7'h05, 2'b11, 16'hBEEF);
      tick();
      set0(0, 0, '0, '0, '0);
      set1(1, 0, 7'h05, 2'b11, '0);
      tick();
      set1(0, 0, '0, '0, '0);
      sample();
      for (int k = 0; k < 2; k++) begin
         chk("beef_rdv1", k, v1[k], 1);
         chk("beef_rdata", k, d1[k], 16'hBEEF);
         chk("beef_rdv0", k, v0[k], 0);
      end
      tick();

      // Byte-lane write at the top address.
      set0(0, 1, 7'h7F, 2'b11, 16'hFFFF);
      tick();
      set0(0, 1, 7'h7F, 2'b01, 16'h1234);
      tick();
      set0(1, 0, 7'h7F, 2'b11, '0);
      tick();
      set0(0, 0, '0, '0, '0);
      sample();
      for (int k = 0; k < 2; k++) begin
         chk("lane_rdv0", k, v0[k], 1);
         chk("lane_rdata", k, d0[k], 16'hFF34);
      end
      tick();

      // Read accepted, reset the next cycle; both request through reset.
      set0(1, 0, 7'h10, 2'b11, '0);
      tick();
      reset = 1'b1;
      set1(1, 0, 7'h11, 2'b11, '0);
      for (int c = 0; c < 2; c++) begin
         sample();
         for (int k = 0; k < 2; k++) begin
            chk("rstmid_rdv0", k, v0[k], 0);
            chk("rstmid_wait0", k, w0[k], 1);
            chk("rstmid_wait1", k, w1[k], 1);
            chk("rstmid_cs", k, cs[k], 0);
         end
         tick();
      end
      reset = 1'b0;
      sample();
      for (int k = 0; k < 2; k++) begin
         chk("post_rst_wait0", k, w0[k], 0);
         chk("post_rst_wait1", k, w1[k], 1);
         chk("post_rst_rdv0", k, v0[k], 0);
      end
      tick();
      set0(0, 0, '0, '0, '0);
      set1(0, 0, '0, '0, '0);
      tick();

      // m1 run broken by one idle cycle, then contention.
      glog0.delete();
      glog1.delete();
      set1(1, 0, 7'h20, 2'b11, '0);
      tick(); tick();
      set1(0, 0, '0, '0, '0);
      tick();
      set1(1, 0, 7'h20, 2'b11, '0);
      tick();
      rec = 1'b1;
      set0(1, 0, 7'h21, 2'b11, '0);
      for (int i = 0; i < 6; i++) tick();
      rec = 1'b0;
      set0(0, 0, '0, '0, '0);
      set1(0, 0, '0, '0, '0);
      tick();
      chk("gap4_len", 0, glog0.size(), 6);
      chk("gap1_len", 1, glog1.size(), 6);
      for (int i = 0; i < 6 && i < glog0.size(); i++) chk("gap_max4", 0, glog0[i], gap4[i]);
      for (int i = 0; i < 6 && i < glog1.size(); i++) chk("gap_max1", 1, glog1[i], gap1[i]);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
